// File: rtl/tx_symbol_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : tx_symbol_gen_if
// Description : Control inputs and valid/ready event bus of the transmit
//               symbol source. The master side is the generator; the slave
//               side is the consumer (TX filter / probe logger).
// Revision    : 1.0 - initial release
// ============================================================================
interface tx_symbol_gen_if #(
    parameter int TIME_WIDTH  = 32,
    parameter int VALUE_WIDTH = 18
);
    logic                          en;
    logic [TIME_WIDTH-1:0]         ui;
    logic signed [VALUE_WIDTH-1:0] amp;
    logic                          out_valid;
    logic                          out_ready;
    logic [TIME_WIDTH-1:0]         out_time;
    logic signed [VALUE_WIDTH-1:0] out_value;
    logic                          out_bit;
    logic [2:0]                    state;

    modport master (
        input  en, ui, amp, out_ready,
        output out_valid, out_time, out_value, out_bit, state
    );

    modport slave (
        output en, ui, amp, out_ready,
        input  out_valid, out_time, out_value, out_bit, state
    );
endinterface
`default_nettype wire

// File: rtl/tx_symbol_gen.sv
`default_nettype none
// ============================================================================
// Module      : tx_symbol_gen
// Description : PRBS7 NRZ symbol source. Emits one (time, value, bit) event
//               per unit interval over a valid/ready handshake. Time is an
//               unsigned fixed-point accumulator; generation stops for good
//               once the next time stamp would no longer be representable.
//               Define TX_FFE_EN to enable 2-tap de-emphasis on the value.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_symbol_gen #(
    parameter int TIME_WIDTH  = 32,
    parameter int VALUE_WIDTH = 18,
    parameter int FFE_SHIFT   = 2
) (
    input  wire logic       clk,
    input  wire logic       rst,
    tx_symbol_gen_if.master bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        STALL = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    localparam logic signed [VALUE_WIDTH-1:0] c_val_max = {1'b0, {(VALUE_WIDTH-1){1'b1}}};
    localparam logic signed [VALUE_WIDTH-1:0] c_val_min = {1'b1, {(VALUE_WIDTH-1){1'b0}}};

    // A post-tap shift of the full value width or more is meaningless.
    if (FFE_SHIFT < 0 || FFE_SHIFT >= VALUE_WIDTH) begin : g_ffe_shift_range
        $error("tx_symbol_gen: FFE_SHIFT out of range");
    end

    state_t                        r_state;
    logic                          r_valid;
    logic [TIME_WIDTH-1:0]         r_time;
    logic signed [VALUE_WIDTH-1:0] r_value;
    logic                          r_bit;
    logic [6:0]                    r_lfsr;
    // Time stamp of the current event, or of the next one while idle.
    logic [TIME_WIDTH-1:0]         r_time_acc;

    logic                          w_start;
    logic                          w_xfer;
    logic                          w_run_xfer;
    logic                          w_gen;
    logic [TIME_WIDTH:0]           w_time_sum;
    logic                          w_time_ovf;
    logic [TIME_WIDTH-1:0]         w_gen_time;
    logic                          w_sym_bit;
    logic [6:0]                    w_lfsr_next;
    logic signed [VALUE_WIDTH-1:0] w_v_neg;
    logic signed [VALUE_WIDTH-1:0] w_v_cur;
    logic signed [VALUE_WIDTH-1:0] w_value;

    assign w_start    = (r_state == IDLE) && bus.en && (bus.ui != '0);
    assign w_xfer     = r_valid && bus.out_ready;
    assign w_run_xfer = w_xfer && ((r_state == RUN) || (r_state == STALL));
    // Carry out of the widened add means the following event cannot be stamped.
    assign w_time_sum = {1'b0, r_time} + {1'b0, bus.ui};
    assign w_time_ovf = w_time_sum[TIME_WIDTH];
    assign w_gen      = w_start || (w_run_xfer && bus.en && !w_time_ovf);
    assign w_gen_time = w_start ? r_time_acc : w_time_sum[TIME_WIDTH-1:0];

    // x^7 + x^6 + 1, shifting left; the symbol is taken from the MSB.
    assign w_sym_bit   = r_lfsr[6];
    assign w_lfsr_next = {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};

    // Negating the most-negative level has no representation; clamp instead.
    assign w_v_neg = (bus.amp == c_val_min) ? c_val_max : -bus.amp;
    assign w_v_cur = w_sym_bit ? bus.amp : w_v_neg;

`ifdef TX_FFE_EN
    logic signed [VALUE_WIDTH-1:0] r_v_prev;
    logic signed [VALUE_WIDTH-1:0] w_v_prev_scaled;
    logic signed [VALUE_WIDTH:0]   w_ffe_diff;

    assign w_v_prev_scaled = r_v_prev >>> FFE_SHIFT;
    assign w_ffe_diff      = {w_v_cur[VALUE_WIDTH-1], w_v_cur}
                           - {w_v_prev_scaled[VALUE_WIDTH-1], w_v_prev_scaled};
    assign w_value = (w_ffe_diff[VALUE_WIDTH] != w_ffe_diff[VALUE_WIDTH-1])
                   ? (w_ffe_diff[VALUE_WIDTH] ? c_val_min : c_val_max)
                   : w_ffe_diff[VALUE_WIDTH-1:0];

    // Previous-symbol level follows every newly generated symbol.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_v_prev <= '0;
        end else if (w_gen) begin
            r_v_prev <= w_v_cur;
        end
    end
`else
    assign w_value = w_v_cur;
`endif

    // Control FSM plus the registered event outputs it presents.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_valid    <= 1'b0;
            r_time     <= '0;
            r_value    <= '0;
            r_bit      <= 1'b0;
            r_lfsr     <= 7'h7F;
            r_time_acc <= '0;
        end else begin
            if (w_gen) begin
                r_time  <= w_gen_time;
                r_value <= w_value;
                r_bit   <= w_sym_bit;
                r_lfsr  <= w_lfsr_next;
            end
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state <= RUN;
                        r_valid <= 1'b1;
                    end
                end
                RUN, STALL: begin
                    if (w_xfer) begin
                        if (w_time_ovf) begin
                            r_state <= DONE;
                            r_valid <= 1'b0;
                        end else begin
                            r_time_acc <= w_time_sum[TIME_WIDTH-1:0];
                            if (bus.en) begin
                                r_state <= RUN;
                            end else begin
                                r_state <= IDLE;
                                r_valid <= 1'b0;
                            end
                        end
                    end else if (!bus.en) begin
                        r_state <= DRAIN;
                    end else begin
                        r_state <= STALL;
                    end
                end
                DRAIN: begin
                    if (w_xfer) begin
                        r_valid <= 1'b0;
                        if (w_time_ovf) begin
                            r_state <= DONE;
                        end else begin
                            r_time_acc <= w_time_sum[TIME_WIDTH-1:0];
                            r_state    <= IDLE;
                        end
                    end
                end
                DONE: begin
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = r_valid;
    assign bus.out_time  = r_time;
    assign bus.out_value = r_value;
    assign bus.out_bit   = r_bit;
    assign bus.state     = r_state;
endmodule
`default_nettype wire

// File: doc/tx_symbol_gen.md
Name: tx_symbol_gen

Overview:
- Transmit-side symbol source of the link emulator.
- Generates a PRBS7 NRZ bit stream and emits one (time, value) event per unit interval (UI).
- Output feeds the TX filter input and the TX probe logger.
- Time is unsigned fixed-point. Value is the signed filter-input amplitude.

Parameters:
- TIME_WIDTH, 32, width of the unsigned fixed-point time stamp.
- VALUE_WIDTH, 18, width of the signed filter-input value.
- FFE_SHIFT, 2, de-emphasis post-tap weight of 2^-FFE_SHIFT (used only with TX_FFE_EN).

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous active-high reset.
- en  input  1  run request.
- ui  input  TIME_WIDTH  UI period, same fixed-point format as out_time.
- amp  input  VALUE_WIDTH  signed level for bit 1; bit 0 drives the negated level.
- out_valid  output  1  event valid.
- out_ready  input  1  downstream accepts the event.
- out_time  output  TIME_WIDTH  UI start time of the event.
- out_value  output  VALUE_WIDTH  filter-input value for this UI.
- out_bit  output  1  PRBS bit for this UI.
- state  output  3  debug state encoding.

Behaviour:
- Clock and reset: single clock, clk. Reset rst is synchronous and active-high, sampled only on the rising edge of clk.
- Reset values:
  - out_valid=0, out_time=0, out_value=0, out_bit=0, state=IDLE.
  - LFSR=7'h7F; internal time accumulator=0; previous-symbol register=0.
- Reset mid-operation: a pending unaccepted event is discarded. out_valid is low from the following cycle.
- Transfer: occurs on a rising edge with out_valid=1 and out_ready=1.
- Handshake rules:
  - While out_valid=1 and out_ready=0, out_time, out_value and out_bit hold stable.
  - out_valid never drops without a transfer, except on rst.
- PRBS: x^7+x^6+1, shift left, new LSB = lfsr[6]^lfsr[5]. Symbol bit = lfsr[6]. The LFSR advances once per generated symbol. Sequence period is 127.
- Value: bit=1 gives amp; bit=0 gives -amp. Negating the most-negative amp saturates to the most-positive value.
- Time: the first event after reset has out_time=0. Each subsequent event has out_time = previous out_time + ui.
- States (encoding on the state port):
  - IDLE(0): out_valid=0. Go to RUN when en=1 and ui!=0. If ui==0, remain in IDLE regardless of en.
  - RUN(1): out_valid=1, presenting the current symbol.
    - Transfer with en=1: next symbol loaded and presented on the following cycle (one event per cycle throughput, out_valid stays high).
    - No transfer: go to STALL.
  - STALL(2): out_valid=1, data held. On transfer, behave exactly as a transfer in RUN.
  - DRAIN(3): entered from RUN or STALL when en falls while an event is pending. Event held until transferred, then go to IDLE.
  - DONE(4): reached when out_time + ui would exceed 2^TIME_WIDTH-1, after the last representable event transfers. out_valid=0. Leaves only on rst.
- Pause and resume: time, LFSR and previous symbol are preserved across IDLE, so re-asserting en resumes the sequence without repetition.
- Generation: a new symbol is generated only at a transfer (or on the IDLE->RUN entry). No symbol is skipped or duplicated.
- Arithmetic: time add is computed at TIME_WIDTH+1 bits; the carry-out is the DONE condition. Value arithmetic saturates to VALUE_WIDTH signed.
- Simultaneous events:
  - en falling in the same cycle as a transfer goes straight to IDLE; no new symbol is generated.
  - An overflow-limited transfer goes to DONE irrespective of en.

Optional Feature:
- TX_FFE_EN defined: 2-tap de-emphasis. out_value = sat(v_cur - (v_prev >>> FFE_SHIFT)), where v_cur is ±amp of this symbol and v_prev is ±amp of the previous generated symbol (0 for the first symbol after reset).
  - v_prev updates only when a new symbol is generated.
- TX_FFE_EN undefined: out_value = v_cur. No previous-symbol register is present.

Test Plan:
- rst, ui=0x100, amp=1000, en=1, out_ready=1 -> out_valid high from the 2nd cycle. Events out_time = 0, 0x100, 0x200, … First 7 bits 1,1,1,1,1,1,1, then 0. Values 1000 ×7, then -1000. Sequence repeats after 127 events.
- Same setup, out_ready low for 5 cycles at event 3 -> state=STALL. out_time=0x300 and value held for all 5 cycles; the next event after release is 0x400.
- en dropped while stalled at event 3 -> state=DRAIN. Event 3 delivered, then IDLE. Re-assert en -> next event out_time=0x400 with PRBS continuing at bit 4.
- TIME_WIDTH=8, ui=0x60 -> events at 0x00, 0x60, 0xC0, then state=DONE with out_valid=0. A later rst restores IDLE with out_time=0.
- ui=0, en=1 for 10 cycles -> remains IDLE with out_valid=0. amp=-131072 -> bit-0 value saturates to 131071.
- With TX_FFE_EN, FFE_SHIFT=2, amp=1000:
  - first event = 1000;
  - repeated 1s = 750;
  - first 0 after 1s = -1250;
  - 0 after 0 = -750.
